// File: rtl/oflow_similarity_scheduler.sv
// Scheduler between the previous-frame feature buffer and one similarity PE:
// streams candidate feature lines to the PE and keeps the minimum score and its id.
module oflow_similarity_scheduler #(
    parameter int DATA_W  = 128,
    parameter int SCORE_W = 32,
    parameter int ID_W    = 12,
    parameter int ADDR_W  = 6
) (
    input  logic                clk,
    input  logic                reset_N,
    input  logic                start,
    input  logic [ADDR_W:0]     num_prev,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                pe_start,
    output logic [DATA_W-1:0]   pe_features_of_prev,
    input  logic                pe_control_for_read_new_line,
    input  logic                pe_valid,
    input  logic [SCORE_W-1:0]  pe_score,
    input  logic [ID_W-1:0]     pe_id,
    output logic                busy,
    output logic                done,
    output logic [SCORE_W-1:0]  best_score,
    output logic [ID_W-1:0]     best_id,
    output logic                no_match
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LAUNCH, S_COMPUTE, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W:0]     idx_nxt;
    logic [DATA_W-1:0]   feat_q, feat_d;
    logic [DATA_W-1:0]   stage_q, stage_d;
    logic                staged_vld_q, staged_vld_d;
    logic                pf_issued_q, pf_issued_d;
    logic                pf_pend_q, pf_pend_d;
    logic [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [ID_W-1:0]     best_id_q, best_id_d;
    logic                no_match_q, no_match_d;
    logic                zero_dly_q, zero_dly_d;

    assign idx_nxt = idx_q + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            feat_q       <= '0;
            staged_vld_q <= 1'b0;
            pf_issued_q  <= 1'b0;
            pf_pend_q    <= 1'b0;
            best_score_q <= '1;
            best_id_q    <= '0;
            no_match_q   <= 1'b0;
            zero_dly_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            feat_q       <= feat_d;
            staged_vld_q <= staged_vld_d;
            pf_issued_q  <= pf_issued_d;
            pf_pend_q    <= pf_pend_d;
            best_score_q <= best_score_d;
            best_id_q    <= best_id_d;
            no_match_q   <= no_match_d;
            zero_dly_q   <= zero_dly_d;
        end
    end

    // Staging line is qualified by staged_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        feat_d       = feat_q;
        stage_d      = stage_q;
        staged_vld_d = staged_vld_q;
        pf_issued_d  = pf_issued_q;
        pf_pend_d    = pf_pend_q;
        best_score_d = best_score_q;
        best_id_d    = best_id_q;
        no_match_d   = no_match_q;
        zero_dly_d   = zero_dly_q;
        mem_rd_en    = 1'b0;
        mem_addr     = '0;
        pe_start     = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d        = num_prev;
                    idx_d        = '0;
                    staged_vld_d = 1'b0;
                    pf_issued_d  = 1'b0;
                    pf_pend_d    = 1'b0;
                    best_score_d = '1;
                    best_id_d    = '0;
                    no_match_d   = 1'b0;
                    if (num_prev == '0) begin
                        zero_dly_d = 1'b1;
                        state_d    = S_FINISH;
                    end else begin
                        state_d    = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = idx_q[ADDR_W-1:0];
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                feat_d  = mem_rd_data;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                pe_start = 1'b1;
                state_d  = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (pf_pend_q) begin
                    stage_d      = mem_rd_data;
                    staged_vld_d = 1'b1;
                    pf_pend_d    = 1'b0;
                end
                // A hint coinciding with the result is left to the fetch path.
                if (pe_control_for_read_new_line && !pe_valid && !pf_issued_q && (idx_nxt < cnt_q)) begin
                    mem_rd_en   = 1'b1;
                    mem_addr    = idx_nxt[ADDR_W-1:0];
                    pf_issued_d = 1'b1;
                    pf_pend_d   = 1'b1;
                end
                if (pe_valid) begin
                    if (pe_score < best_score_q) begin
                        best_score_d = pe_score;
                        best_id_d    = pe_id;
                    end
                    pf_issued_d  = 1'b0;
                    pf_pend_d    = 1'b0;
                    staged_vld_d = 1'b0;
                    if (idx_nxt == cnt_q) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d = idx_nxt;
                        if (staged_vld_q) begin
                            feat_d  = stage_q;
                            state_d = S_LAUNCH;
                        end else if (pf_pend_q) begin
                            feat_d  = mem_rd_data;
                            state_d = S_LAUNCH;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_FINISH: begin
                no_match_d = (cnt_q == '0);
                // An empty scan spends one extra cycle here before reporting.
                if (zero_dly_q) begin
                    zero_dly_d = 1'b0;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy                = (state_q != S_IDLE);
    assign pe_features_of_prev = feat_q;
    assign best_score          = best_score_q;
    assign best_id             = best_id_q;
    assign no_match            = no_match_q;

endmodule

// File: tb/tb_oflow_similarity_scheduler.sv
// Randomized bench for oflow_similarity_scheduler with a buffer model, a PE model
// and a min-score reference computed directly from the candidate tables.
module tb_oflow_similarity_scheduler;

    localparam int DATA_W  = 128;
    localparam int SCORE_W = 32;
    localparam int ID_W    = 12;
    localparam int ADDR_W  = 6;
    localparam logic [SCORE_W-1:0] ALL1 = '1;

    logic                clk = 1'b0;
    logic                reset_N = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W:0]     num_prev = '0;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rd_data = '0;
    logic                pe_start;
    logic [DATA_W-1:0]   pe_features_of_prev;
    logic                pe_ctrl = 1'b0;
    logic                pe_valid = 1'b0;
    logic [SCORE_W-1:0]  pe_score = '0;
    logic [ID_W-1:0]     pe_id = '0;
    logic                busy;
    logic                done;
    logic [SCORE_W-1:0]  best_score;
    logic [ID_W-1:0]     best_id;
    logic                no_match;

    oflow_similarity_scheduler #(
        .DATA_W(DATA_W), .SCORE_W(SCORE_W), .ID_W(ID_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_N(reset_N), .start(start), .num_prev(num_prev),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pe_start(pe_start), .pe_features_of_prev(pe_features_of_prev),
        .pe_control_for_read_new_line(pe_ctrl), .pe_valid(pe_valid),
        .pe_score(pe_score), .pe_id(pe_id), .busy(busy), .done(done),
        .best_score(best_score), .best_id(best_id), .no_match(no_match)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    int n_cmp = 0;
    int n_bad = 0;
    int fix_sc[$];
    int fix_id[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_pe_start"}, pe_start, 0);
        chk({tag, "_feat"}, pe_features_of_prev == '0, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_score"}, best_score, ALL1);
        chk({tag, "_id"}, best_id, 0);
        chk({tag, "_nomatch"}, no_match, 0);
    endtask

    // hint_mode: 0 none, 1 hint two cycles before valid, 2 one cycle before, 3 both
    task automatic run_scan(input int n, input int hint_mode, input bit restart, input bit do_reset);
        logic [SCORE_W-1:0] sc[$];
        logic [ID_W-1:0]    ids[$];
        logic [SCORE_W-1:0] exp_s;
        logic [ID_W-1:0]    exp_id;
        int  tval, k, reads, starts, dones, exp_start, exp_rd, exp_done, launch_cyc;
        bit  pe_run, finished;
        for (int i = 0; i < n; i++) begin
            if (fix_sc.size() == n) begin
                sc.push_back(SCORE_W'(fix_sc[i]));
                ids.push_back(ID_W'(fix_id[i]));
            end else begin
                sc.push_back(SCORE_W'($urandom_range(0, 40)));
                ids.push_back(ID_W'($urandom_range(1, 4095)));
            end
            mem[i] = {$urandom, $urandom, $urandom, 20'h0, ids[i]};
        end
        fix_sc.delete();
        fix_id.delete();
        exp_s  = ALL1;
        exp_id = '0;
        for (int i = 0; i < n; i++)
            if (sc[i] < exp_s) begin exp_s = sc[i]; exp_id = ids[i]; end

        tval = -1; k = 0; reads = 0; starts = 0; dones = 0; pe_run = 0; finished = 0;
        launch_cyc = -1; exp_start = 3; exp_rd = (n > 0) ? 1 : -1; exp_done = (n == 0) ? 2 : -1;
        @(negedge clk);
        start = 1'b1;
        num_prev = (ADDR_W+1)'(n);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (restart && cyc == 6) begin start = 1'b1; num_prev = 7'd5; end
            if (restart && cyc == 7) start = 1'b0;
            pe_valid = 1'b0;
            pe_ctrl  = 1'b0;
            if (pe_run) begin
                if (cyc == tval) begin pe_valid = 1'b1; pe_score = sc[k]; pe_id = ids[k]; end
                if ((hint_mode == 1 || hint_mode == 3) && cyc == tval - 2) pe_ctrl = 1'b1;
                if ((hint_mode == 2 || hint_mode == 3) && cyc == tval - 1) pe_ctrl = 1'b1;
            end
            if (do_reset && starts == 2 && cyc == launch_cyc + 2) begin
                reset_N = 1'b0;
                #1;
                check_reset("rst_mid");
                @(negedge clk);
                reset_N  = 1'b1;
                pe_valid = 1'b0;
                pe_ctrl  = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    #1;
                    chk("rst_no_done", done, 0);
                end
                return;
            end
            #1;
            if (cyc == 1) chk("busy_scan", busy, 1);
            if (mem_rd_en) begin
                chk("rd_addr", mem_addr, reads);
                if (exp_rd >= 0) begin chk("rd_cyc", cyc, exp_rd); exp_rd = -1; end
                reads++;
            end else if (cyc == exp_rd) begin
                chk("rd_en", mem_rd_en, 1);
                exp_rd = -1;
            end
            if (pe_start) begin
                chk("start_cyc", cyc, exp_start);
                if (starts < n) chk("feat", pe_features_of_prev == mem[starts], 1);
                else chk("start_extra", starts + 1, n);
                k = starts;
                starts++;
                pe_run = 1;
                launch_cyc = cyc;
                exp_start = -1;
                tval = cyc + $urandom_range(3, 7);
            end
            if (pe_valid) begin
                pe_run = 0;
                if (k == n - 1) exp_done = cyc + 1;
                else if (hint_mode == 0) begin exp_rd = cyc + 1; exp_start = cyc + 3; end
                else exp_start = cyc + 1;
            end
            if (done) begin
                dones++;
                chk("done_cyc", cyc, exp_done);
                chk("best_score", best_score, exp_s);
                chk("best_id", best_id, exp_id);
                chk("no_match", no_match, n == 0);
            end
            if (exp_done >= 0 && cyc == exp_done + 2) begin
                chk("busy_after", busy, 0);
                chk("done_count", dones, 1);
                chk("start_count", starts, n);
                chk("read_count", reads, n);
                chk("held_score", best_score, exp_s);
                finished = 1;
                break;
            end
        end
        chk("scan_end", finished, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst_init");
        reset_N = 1'b1;

        fix_sc = '{50, 20, 30}; fix_id = '{5, 6, 7};
        run_scan(3, 1, 0, 0);
        fix_sc = '{40, 40}; fix_id = '{11, 12};
        run_scan(2, 2, 0, 0);
        run_scan(0, 1, 0, 0);
        run_scan(2, 0, 0, 0);
        run_scan(3, 1, 1, 0);
        run_scan(3, 3, 0, 1);
        run_scan(3, 1, 0, 0);
        run_scan(64, 3, 0, 0);
        for (int r = 0; r < 25; r++)
            run_scan($urandom_range(0, 12), $urandom_range(0, 3), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oflow_similarity_scheduler.md
# oflow_similarity_scheduler

Feeds history-object feature lines from the previous-frame feature buffer to one similarity-metric PE, one candidate at a time, and collects the PE's score/id results. Tracks the minimum score and its id over all candidates and reports the best match for the current object. It sits between the feature buffer (synchronous-read RAM) and the PE. It drives `start`/`features_of_prev` and consumes `control_for_read_new_line`/`valid`/`score`/`id`.

## Interface
- DATA_W, 128, width of one feature line (PE `features_of_prev`)
- SCORE_W, 32, PE score width (q26.6, unsigned)
- ID_W, 12, object id width
- ADDR_W, 6, feature buffer address width (max 2^ADDR_W candidates)

- clk  in  1  clock
- reset_N  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a scan for the current object; ignored while busy=1
- num_prev  in  ADDR_W+1  candidate count, 0..2^ADDR_W; sampled with start
- mem_rd_en  out  1  buffer read strobe; data valid on mem_rd_data the following cycle
- mem_addr  out  ADDR_W  buffer read address
- mem_rd_data  in  DATA_W  buffer read data
- pe_start  out  1  one-cycle start pulse to PE
- pe_features_of_prev  out  DATA_W  registered feature line; held stable from pe_start until the cycle after pe_valid
- pe_control_for_read_new_line  in  1  PE prefetch hint
- pe_valid  in  1  PE result valid, one cycle
- pe_score  in  SCORE_W  PE score
- pe_id  in  ID_W  PE id
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: best_score/best_id/no_match valid and held until next start
- best_score  out  SCORE_W  minimum score seen
- best_id  out  ID_W  id of minimum score
- no_match  out  1  scan finished with num_prev=0

## Operation
- States: IDLE, FETCH, WAIT, LAUNCH, COMPUTE, FINISH.
- IDLE: on start with busy=0, latch num_prev into cnt_reg, clear idx=0, staged_valid=0, set best_score to all-ones, best_id=0, no_match=0. Go to FINISH if num_prev=0, else go to FETCH.
- FETCH: mem_rd_en=1, mem_addr=idx. Go to WAIT.
- WAIT: feature_reg<=mem_rd_data. Go to LAUNCH.
- LAUNCH: pe_start=1 for exactly this cycle. Go to COMPUTE.
- COMPUTE: on pe_control_for_read_new_line with idx+1<cnt_reg and no prefetch yet issued for this candidate:
  - mem_rd_en=1, mem_addr=idx+1.
  - Next cycle, staging_reg<=mem_rd_data and staged_valid<=1.
  - Extra hint pulses are ignored.
- COMPUTE, on pe_valid:
  - Compare: if pe_score < best_score (strict, unsigned), update best_score<=pe_score and best_id<=pe_id. Ties keep the earlier candidate.
  - If idx+1=cnt_reg, go to FINISH.
  - Else idx<=idx+1, then:
    - if staged_valid: feature_reg<=staging_reg, staged_valid<=0, go to LAUNCH;
    - else if the prefetch read data arrives this same cycle: feature_reg<=mem_rd_data (bypass), go to LAUNCH;
    - else go to FETCH (fallback when no hint was seen).
- FINISH: done=1 for one cycle. no_match=1 if cnt_reg=0. Go to IDLE.
- busy=1 in every state except IDLE.
- pe_valid outside COMPUTE is ignored. pe_control_for_read_new_line outside COMPUTE is ignored.

## Timing
- Reset values: mem_rd_en=0, mem_addr=0, pe_start=0, pe_features_of_prev=0, busy=0, done=0, best_score=all-ones, best_id=0, no_match=0. State returns to IDLE.
- Reset mid-scan aborts the scan immediately. No done pulse is produced.
- First candidate: start sampled in cycle 0; mem_rd_en in cycle 1; feature_reg loaded at end of cycle 2; pe_start in cycle 3.
- Back-to-back candidate with prefetch: pe_valid in cycle T; pe_start in cycle T+1 with the new features already on pe_features_of_prev. This matches the PE returning to idle at T+1.
- Fallback candidate (no hint): pe_valid at T; mem_rd_en at T+1; pe_start at T+3.
- Last candidate: pe_valid at T; done=1 at T+1 with updated best_score/best_id visible in the same cycle.
- num_prev=0: start at cycle 0; done=1 and no_match=1 at cycle 2.
- start coinciding with the done cycle is ignored. A new scan requires start while in IDLE.

## Test plan
- num_prev=3, buffer ids 5/6/7, PE scores 50/20/30, hint asserted 2 cycles before each valid -> done with best_score=20, best_id=6; pe_start exactly 1 cycle after each of the first two pe_valid; mem_addr sequence 0,1,2.
- num_prev=2, equal scores 40/40 -> best_id is the first candidate's id; best_score=40.
- num_prev=0 -> no pe_start, no mem_rd_en, done=1 and no_match=1 at cycle 2, best_score=all-ones.
- num_prev=2 with the hint never asserted -> second pe_start at pe_valid+3, via mem_rd_en at pe_valid+1 with mem_addr=1; result still correct.
- start pulsed again mid-scan with num_prev=5 -> ignored; original scan of 3 completes with a single done.
- reset_N asserted during COMPUTE of candidate 1 -> all outputs at reset values the same cycle; no done; a subsequent start runs a clean scan from addr 0.
